// File: rtl/countdown_timer_mmss.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_mmss
// Brief    : BCD MM:SS countdown timer with load, start/pause and expiry pulse.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer_mmss (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       LD,
  input  logic       Start,
  input  logic       Stop,
  input  logic [2:0] IN_MT,
  input  logic [3:0] IN_MU,
  input  logic [2:0] IN_ST,
  input  logic [3:0] IN_SU,
  output logic [2:0] MT,
  output logic [3:0] MU,
  output logic [2:0] ST,
  output logic [3:0] SU,
  output logic       Running,
  output logic       Done,
  output logic       Expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] w_mt_nxt, w_st_nxt;
  logic [3:0] w_mu_nxt, w_su_nxt;
  logic       w_done_nxt;
  logic       w_zero, w_one;

  assign w_zero  = (MT == 3'd0) && (MU == 4'd0) && (ST == 3'd0) && (SU == 4'd0);
  assign w_one   = (MT == 3'd0) && (MU == 4'd0) && (ST == 3'd0) && (SU == 4'd1);
  assign Running = (r_state == RUN);
  assign Expired = (r_state == EXPIRED);

  // Command priority below the async clear: LD, Stop, Start, Tick.
  always_comb begin
    w_state_nxt = r_state;
    w_mt_nxt    = MT;
    w_mu_nxt    = MU;
    w_st_nxt    = ST;
    w_su_nxt    = SU;
    w_done_nxt  = 1'b0;
    if (LD) begin
      w_mt_nxt    = (IN_MT > 3'd5) ? 3'd5 : IN_MT;
      w_mu_nxt    = (IN_MU > 4'd9) ? 4'd9 : IN_MU;
      w_st_nxt    = (IN_ST > 3'd5) ? 3'd5 : IN_ST;
      w_su_nxt    = (IN_SU > 4'd9) ? 4'd9 : IN_SU;
      w_state_nxt = IDLE;
    end else if (Stop) begin
      if (r_state == RUN)
        w_state_nxt = PAUSE;
      else if (r_state == EXPIRED)
        w_state_nxt = IDLE;
    end else if (Start && ((r_state == IDLE) || (r_state == PAUSE))) begin
      if (!w_zero)
        w_state_nxt = RUN;
    end else if (Tick && (r_state == RUN) && !w_zero) begin
      // Borrow ripples SU -> ST -> MU -> MT; zero count is excluded above.
      if (SU != 4'd0) begin
        w_su_nxt = SU - 4'd1;
      end else begin
        w_su_nxt = 4'd9;
        if (ST != 3'd0) begin
          w_st_nxt = ST - 3'd1;
        end else begin
          w_st_nxt = 3'd5;
          if (MU != 4'd0) begin
            w_mu_nxt = MU - 4'd1;
          end else begin
            w_mu_nxt = 4'd9;
            w_mt_nxt = MT - 3'd1;
          end
        end
      end
      if (w_one) begin
        w_state_nxt = EXPIRED;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state <= IDLE;
      MT      <= 3'd0;
      MU      <= 4'd0;
      ST      <= 3'd0;
      SU      <= 4'd0;
      Done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      MT      <= w_mt_nxt;
      MU      <= w_mu_nxt;
      ST      <= w_st_nxt;
      SU      <= w_su_nxt;
      Done    <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_mmss.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer_mmss
// Brief    : Self-checking bench; reference model counts plain seconds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_mmss;

  logic       Clk, Clr, Tick, LD, Start, Stop;
  logic [2:0] IN_MT, IN_ST, MT, ST;
  logic [3:0] IN_MU, IN_SU, MU, SU;
  logic       Running, Done, Expired;

  int checks = 0;
  int passes = 0;

  // Model: remaining seconds and a mode (0 idle, 1 run, 2 pause, 3 expired).
  int m_secs = 0;
  int m_mode = 0;
  bit m_done = 0;

  countdown_timer_mmss dut (
    .Clk(Clk), .Clr(Clr), .Tick(Tick), .LD(LD), .Start(Start), .Stop(Stop),
    .IN_MT(IN_MT), .IN_MU(IN_MU), .IN_ST(IN_ST), .IN_SU(IN_SU),
    .MT(MT), .MU(MU), .ST(ST), .SU(SU),
    .Running(Running), .Done(Done), .Expired(Expired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int clip(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [16:0] obs();
    return {Running, Expired, Done, MT, MU, ST, SU};
  endfunction

  function automatic logic [16:0] expv();
    logic [2:0] mt, st;
    logic [3:0] mu, su;
    mt = 3'(m_secs / 600);
    mu = 4'((m_secs / 60) % 10);
    st = 3'((m_secs % 60) / 10);
    su = 4'(m_secs % 10);
    return {(m_mode == 1), (m_mode == 3), m_done, mt, mu, st, su};
  endfunction

  task automatic model_step(input bit ld, input bit sta, input bit stp, input bit tk,
                            input int a, input int b, input int c, input int d);
    m_done = 0;
    if (ld) begin
      m_secs = clip(a, 5) * 600 + clip(b, 9) * 60 + clip(c, 5) * 10 + clip(d, 9);
      m_mode = 0;
    end else if (stp) begin
      if (m_mode == 1) m_mode = 2;
      else if (m_mode == 3) m_mode = 0;
    end else if (sta && (m_mode == 0 || m_mode == 2)) begin
      if (m_secs != 0) m_mode = 1;
    end else if (tk && m_mode == 1) begin
      m_secs = m_secs - 1;
      if (m_secs == 0) begin
        m_mode = 3;
        m_done = 1;
      end
    end
  endtask

  // One clock: drive, take the edge, advance the model, settle 1ns past the edge.
  task automatic step(input bit ld, input bit sta, input bit stp, input bit tk,
                      input int a = 0, input int b = 0, input int c = 0, input int d = 0);
    LD = ld; Start = sta; Stop = stp; Tick = tk;
    IN_MT = 3'(a); IN_MU = 4'(b); IN_ST = 3'(c); IN_SU = 4'(d);
    @(posedge Clk);
    model_step(ld, sta, stp, tk, a, b, c, d);
    #1;
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    #2 Clr = 1'b0;
    #1;
    m_secs = 0; m_mode = 0; m_done = 0;
    checks++;
    if (obs() !== expv())
      $display("FAIL reset_async obs=%h exp=%h", obs(), expv());
    else passes++;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Clr = 1'b1;
    step(0, 0, 0, 1);
    checks++;
    if (obs() !== expv())
      $display("FAIL reset_idle_tick obs=%h exp=%h", obs(), expv());
    else passes++;
  endtask

  task automatic test_expiry();
    step(1, 0, 0, 0, 0, 0, 0, 3);
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, (i < 3));
      checks++;
      if (obs() !== expv())
        $display("FAIL expiry_%0d obs=%h exp=%h", i, obs(), expv());
      else passes++;
    end
    step(0, 1, 0, 1);
    checks++;
    if (obs() !== expv())
      $display("FAIL expired_start_ignored obs=%h exp=%h", obs(), expv());
    else passes++;
    step(0, 0, 1, 0);
    checks++;
    if (obs() !== expv())
      $display("FAIL expired_stop_to_idle obs=%h exp=%h", obs(), expv());
    else passes++;
    step(0, 1, 0, 0);
    checks++;
    if (obs() !== expv())
      $display("FAIL start_at_zero obs=%h exp=%h", obs(), expv());
    else passes++;
  endtask

  task automatic test_borrow();
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    checks++;
    if (obs() !== expv() || {MT, MU, ST, SU} !== {3'd0, 4'd9, 3'd5, 4'd9})
      $display("FAIL borrow_chain obs=%h exp=%h", obs(), expv());
    else passes++;
  endtask

  task automatic test_pause_resume();
    bit st_v [11] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    bit sp_v [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    bit tk_v [11] = '{0, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0};
    step(1, 0, 0, 0, 0, 0, 0, 5);
    step(0, 1, 0, 0);
    for (int i = 1; i < 11; i++) begin
      step(0, st_v[i], sp_v[i], tk_v[i]);
      checks++;
      if (obs() !== expv())
        $display("FAIL pause_resume_%0d obs=%h exp=%h", i, obs(), expv());
      else passes++;
    end
  endtask

  task automatic test_saturate();
    step(1, 0, 0, 0, 7, 12, 6, 15);
    checks++;
    if (obs() !== expv() || {MT, MU, ST, SU} !== {3'd5, 4'd9, 3'd5, 4'd9})
      $display("FAIL saturate obs=%h exp=%h", obs(), expv());
    else passes++;
  endtask

  task automatic test_full_run();
    int ticks = 0;
    step(1, 0, 0, 0, 5, 9, 5, 9);
    step(0, 1, 0, 0);
    while (Running === 1'b1 && ticks < 4000) begin
      step(0, 0, 0, 1);
      ticks++;
      checks++;
      if (obs() !== expv())
        $display("FAIL full_run_tick_%0d obs=%h exp=%h", ticks, obs(), expv());
      else passes++;
    end
    checks++;
    if (ticks !== 3599)
      $display("FAIL full_run_length got=%0d want=3599", ticks);
    else passes++;
  endtask

  task automatic test_ld_final_tick();
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0, 3, 0);
    checks++;
    if (obs() !== expv())
      $display("FAIL ld_final_tick obs=%h exp=%h", obs(), expv());
    else passes++;
    step(0, 0, 0, 1);
    checks++;
    if (obs() !== expv())
      $display("FAIL ld_final_tick_after obs=%h exp=%h", obs(), expv());
    else passes++;
  endtask

  task automatic test_clr_midrun();
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    #2 Clr = 1'b0;
    #1;
    m_secs = 0; m_mode = 0; m_done = 0;
    checks++;
    if (obs() !== expv())
      $display("FAIL clr_midrun obs=%h exp=%h", obs(), expv());
    else passes++;
    #2 Clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      checks++;
      if (obs() !== expv())
        $display("FAIL clr_tick_ignored_%0d obs=%h exp=%h", i, obs(), expv());
      else passes++;
    end
    step(1, 0, 0, 0, 0, 0, 0, 2);
    checks++;
    if (obs() !== expv())
      $display("FAIL first_edge_after_clr obs=%h exp=%h", obs(), expv());
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit ld, sta, stp, tk;
      int a, b, c, d;
      ld  = ($urandom_range(0, 99) < 4);
      stp = ($urandom_range(0, 99) < 5);
      sta = ($urandom_range(0, 99) < 10);
      tk  = !sta && ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 1) == 1) begin
        a = 0; b = 0; c = $urandom_range(0, 1); d = $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 7); b = $urandom_range(0, 15);
        c = $urandom_range(0, 7); d = $urandom_range(0, 15);
      end
      step(ld, sta, stp, tk, a, b, c, d);
      checks++;
      if (obs() !== expv())
        $display("FAIL random_%0d obs=%h exp=%h", i, obs(), expv());
      else passes++;
    end
  endtask

  initial begin
    Clr = 1'b1; LD = 0; Start = 0; Stop = 0; Tick = 0;
    IN_MT = 0; IN_MU = 0; IN_ST = 0; IN_SU = 0;
    test_reset();
    test_expiry();
    test_borrow();
    test_pause_resume();
    test_saturate();
    test_ld_final_tick();
    test_clr_midrun();
    test_full_run();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
